l2_input_mem: RTL

Layer-2 input feature-map buffer: the responder on the scheduler's L1→L2 transfer interface. Accepts one DATA_SIZE word per cycle while `l2_inmem_wantwrite` is high, addressed by the (x, y, channel) index triple the scheduler steps. Serves the L2 compute engine with 2×2 window bursts. Reports fill completion so the L2 start can be cross-checked.

---
 rtl/dnn_pkg.sv | 35 +++
 rtl/l2_input_mem_if.sv | 37 +++
 rtl/l2_input_mem_sp_ram.sv | 34 +++
 rtl/l2_input_mem.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared DNN accelerator package.
// Holds the layer-2 geometry, the derived buffer depth and address width,
// the read FSM state type (also used by the scheduler), and the flat
// address helper for the (x, y, channel) index triple.
package dnn_pkg;

    localparam int DATA_SIZE     = 64;
    localparam int l2_NUM_INPUT  = 16;
    localparam int l2_INPUT_DIM  = 26;
    localparam int L2_KERNEL_DIM = 2;

    localparam int DEPTH = l2_NUM_INPUT * l2_INPUT_DIM * l2_INPUT_DIM;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_0     = 3'd1,
        RD_1     = 3'd2,
        RD_2     = 3'd3,
        RD_3     = 3'd4,
        RD_DRAIN = 3'd5
    } rd_state_t;

    localparam logic [AW-1:0] DIM_AW   = AW'(l2_INPUT_DIM);
    localparam logic [AW-1:0] PLANE_AW = AW'(l2_INPUT_DIM * l2_INPUT_DIM);

    // Flat address c*DIM*DIM + y*DIM + x; callers range-check first, so the
    // result always fits in AW bits.
    function automatic logic [AW-1:0] calc_addr(input logic [AW-1:0] x,
                                                input logic [AW-1:0] y,
                                                input logic [AW-1:0] c);
        return (c * PLANE_AW) + (y * DIM_AW) + x;
    endfunction

endpackage

// File: rtl/l2_input_mem_if.sv
// Bus between the scheduler / L2 engine (master) and l2_input_mem (slave).
// Write side: wantwrite strobe, index triple, data, clear, fill status.
// Read side: window request with top-left corner, ready, 4-beat response.
interface l2_input_mem_if;
    import dnn_pkg::*;

    logic                 l2_inmem_wantwrite;
    logic [15:0]          wr_index_x;
    logic [15:0]          wr_index_y;
    logic [15:0]          wr_index_c;
    logic [DATA_SIZE-1:0] wr_data;
    logic                 clear;
    logic [AW:0]          fill_count;
    logic                 full;
    logic                 wr_err;
    logic                 rd_req;
    logic [15:0]          rd_x;
    logic [15:0]          rd_y;
    logic [15:0]          rd_c;
    logic                 rd_ready;
    logic                 rd_valid;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 rd_last;

    modport slave (
        input  l2_inmem_wantwrite, wr_index_x, wr_index_y, wr_index_c, wr_data, clear,
        input  rd_req, rd_x, rd_y, rd_c,
        output fill_count, full, wr_err, rd_ready, rd_valid, rd_data, rd_last
    );

    modport master (
        output l2_inmem_wantwrite, wr_index_x, wr_index_y, wr_index_c, wr_data, clear,
        output rd_req, rd_x, rd_y, rd_c,
        input  fill_count, full, wr_err, rd_ready, rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/l2_input_mem_sp_ram.sv
// sp_ram: single-port synchronous RAM with a 1-cycle registered read.
// Write-first: on a write cycle the read register takes the written word.
// Ports: clk, en (access enable), we (write enable), addr, wdata, rdata.
module sp_ram #(
    parameter int ENTRIES = 16,
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [ENTRIES];
    logic [WIDTH-1:0] q_r;

    // Storage array and read register; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wdata;
                q_r         <= wdata;
            end else begin
                q_r <= mem_r[addr];
            end
        end
    end

    assign rdata = q_r;

endmodule

// File: rtl/l2_input_mem.sv
// l2_input_mem: layer-2 input feature-map buffer.
// Ports: clk, reset (synchronous, active-low), bus (l2_input_mem_if.slave).
// Writes land one word per cycle from the scheduler; the L2 engine reads
// 2x2 windows as exact 4-beat bursts, with out-of-map elements returned as 0.
// Writes own the single RAM port; a burst stalls for each overlapping write.
module l2_input_mem
    import dnn_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    l2_input_mem_if.slave   bus
);

    localparam logic [15:0] DIM16   = 16'(l2_INPUT_DIM);
    localparam logic [15:0] NUM16   = 16'(l2_NUM_INPUT);
    localparam logic [16:0] DIM17   = 17'(l2_INPUT_DIM);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic                 wr_in_range_s, wr_ok_s, wr_bad_s;
    logic [AW-1:0]        wr_addr_s, rd_addr_s, ram_addr_s;
    logic [AW:0]          count_base_s, count_next_s, fill_count_r;
    logic                 full_r, wr_err_r, err_next_s;
    rd_state_t            rd_state_r, burst_next_s;
    logic [15:0]          base_x_r, base_y_r, base_c_r;
    logic [1:0]           elem_idx_s;
    logic [16:0]          elem_x_s, elem_y_s;
    logic                 elem_pad_s, in_burst_s, rd_issue_s;
    logic                 rd_valid_r, rd_last_r, rd_pad_r;
    logic                 ram_en_s;
    logic [DATA_SIZE-1:0] ram_q_s;

    // Write-side decode: range check precedes address arithmetic.
    assign wr_in_range_s = (bus.wr_index_x < DIM16) && (bus.wr_index_y < DIM16) &&
                           (bus.wr_index_c < NUM16);
    assign wr_ok_s   = bus.l2_inmem_wantwrite && wr_in_range_s;
    assign wr_bad_s  = bus.l2_inmem_wantwrite && !wr_in_range_s;
    assign wr_addr_s = calc_addr(bus.wr_index_x[AW-1:0], bus.wr_index_y[AW-1:0],
                                 bus.wr_index_c[AW-1:0]);

    // Next fill count / error: clear applies first, then this cycle's write.
    always_comb begin
        count_base_s = bus.clear ? '0 : fill_count_r;
        if (wr_ok_s && (count_base_s != DEPTH_C)) begin
            count_next_s = count_base_s + (AW+1)'(1);
        end else begin
            count_next_s = count_base_s;
        end
        err_next_s = (bus.clear ? 1'b0 : wr_err_r) | wr_bad_s;
    end

    // Fill status registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_count_r <= '0;
            full_r       <= 1'b0;
            wr_err_r     <= 1'b0;
        end else begin
            fill_count_r <= count_next_s;
            full_r       <= (count_next_s == DEPTH_C);
            wr_err_r     <= err_next_s;
        end
    end

    // Window element selection: bit 0 steps x, bit 1 steps y.
    always_comb begin
        case (rd_state_r)
            RD_0:    begin elem_idx_s = 2'd0; burst_next_s = RD_1;     end
            RD_1:    begin elem_idx_s = 2'd1; burst_next_s = RD_2;     end
            RD_2:    begin elem_idx_s = 2'd2; burst_next_s = RD_3;     end
            RD_3:    begin elem_idx_s = 2'd3; burst_next_s = RD_DRAIN; end
            default: begin elem_idx_s = 2'd0; burst_next_s = RD_IDLE;  end
        endcase
    end

    // 17-bit element coordinates so x+1 / y+1 never wrap before the check.
    assign elem_x_s   = {1'b0, base_x_r} + 17'(elem_idx_s[0]);
    assign elem_y_s   = {1'b0, base_y_r} + 17'(elem_idx_s[1]);
    assign elem_pad_s = (elem_x_s >= DIM17) || (elem_y_s >= DIM17) || (base_c_r >= NUM16);
    assign rd_addr_s  = calc_addr(elem_x_s[AW-1:0], elem_y_s[AW-1:0], base_c_r[AW-1:0]);

    assign in_burst_s = (rd_state_r == RD_0) || (rd_state_r == RD_1) ||
                        (rd_state_r == RD_2) || (rd_state_r == RD_3);
    assign rd_issue_s = in_burst_s && !bus.l2_inmem_wantwrite && !elem_pad_s;

    // Writes own the port; reads only go out on write-free cycles.
    assign ram_en_s   = wr_ok_s || rd_issue_s;
    assign ram_addr_s = wr_ok_s ? wr_addr_s : rd_addr_s;

    sp_ram #(
        .ENTRIES (DEPTH),
        .WIDTH   (DATA_SIZE),
        .ADDR_W  (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (wr_ok_s),
        .addr  (ram_addr_s),
        .wdata (bus.wr_data),
        .rdata (ram_q_s)
    );

    // Read burst FSM with registered beat flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_state_r <= RD_IDLE;
            base_x_r   <= '0;
            base_y_r   <= '0;
            base_c_r   <= '0;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_pad_r   <= 1'b0;
        end else begin
            case (rd_state_r)
                RD_IDLE: begin
                    rd_valid_r <= 1'b0;
                    rd_last_r  <= 1'b0;
                    if (bus.rd_req && bus.rd_ready) begin
                        base_x_r   <= bus.rd_x;
                        base_y_r   <= bus.rd_y;
                        base_c_r   <= bus.rd_c;
                        rd_state_r <= RD_0;
                    end else begin
                        rd_state_r <= RD_IDLE;
                    end
                end
                RD_0, RD_1, RD_2, RD_3: begin
                    if (bus.l2_inmem_wantwrite) begin
                        // Stall: this beat slips one cycle.
                        rd_valid_r <= 1'b0;
                        rd_last_r  <= 1'b0;
                    end else begin
                        rd_valid_r <= 1'b1;
                        rd_pad_r   <= elem_pad_s;
                        rd_last_r  <= (rd_state_r == RD_3);
                        rd_state_r <= burst_next_s;
                    end
                end
                RD_DRAIN: begin
                    rd_valid_r <= 1'b0;
                    rd_last_r  <= 1'b0;
                    rd_state_r <= RD_IDLE;
                end
                default: begin
                    rd_valid_r <= 1'b0;
                    rd_last_r  <= 1'b0;
                    rd_state_r <= RD_IDLE;
                end
            endcase
        end
    end

    assign bus.fill_count = fill_count_r;
    assign bus.full       = full_r;
    assign bus.wr_err     = wr_err_r;
    assign bus.rd_ready   = (rd_state_r == RD_IDLE) && !bus.l2_inmem_wantwrite;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd_last    = rd_last_r;
    // RAM read register gated by registered flags: padded or idle beats read 0.
    assign bus.rd_data    = (rd_valid_r && !rd_pad_r) ? ram_q_s : '0;

endmodule
